gen_m_seq_ctrl: RTL

Sequencer that programs the Gen_M generator from a small table of (x, dwell) steps. It drives Gen_M's 11-bit `x` setting and an enable gate, holds each step for a programmed number of 5 ms ticks, then advances, optionally looping. It sits between the host or button-level control logic and the Gen_M instance, sharing Gen_M's `clk` and `ce5ms` strobe.

---
 rtl/gen_m_pkg.sv | 24 ++
 rtl/gen_m_prog_ram.sv | 34 +++
 rtl/gen_m_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gen_m_pkg.sv
// gen_m_pkg
// Shared constants and types for the Gen_M step sequencer.
//   XW      : width of the Gen_M x setting
//   DW      : dwell counter width, counted in ce5ms ticks
//   N_ENTRY : depth of the step table (power of two)
//   entry_t : one table entry {x, dwell}
//   state_t : sequencer FSM states
package gen_m_pkg;

  localparam int XW      = 11;
  localparam int DW      = 8;
  localparam int N_ENTRY = 8;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [DW-1:0] dwell;
  } entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gen_m_prog_ram.sv
// gen_m_prog_ram
// Step table storage: N_ENTRY words, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk     : system clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : packed {x, dwell} word to store
//   rd_addr : read address
//   rd_data : packed {x, dwell} word at rd_addr
module gen_m_prog_ram #(
  parameter int N_ENTRY = 8,
  parameter int WW      = 19
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(N_ENTRY)-1:0] wr_addr,
  input  logic [WW-1:0]              wr_data,
  input  logic [$clog2(N_ENTRY)-1:0] rd_addr,
  output logic [WW-1:0]              rd_data
);

  logic [WW-1:0] r_mem [N_ENTRY];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read: a load on the same edge as a write to that address
  // captures the word as it was before the edge.
  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/gen_m_seq_ctrl.sv
// gen_m_seq_ctrl
// Steps the Gen_M x setting through a programmed table of (x, dwell)
// entries, holding each for dwell ce5ms ticks (0 means 2^DW), optionally
// looping back to entry 0 after the last active entry.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ce5ms      : 5 ms tick strobe shared with Gen_M
//   wr_*       : table write port (usable in any state)
//   len, loop  : active entry count and loop flag, latched on start
//   start/stop : start request (IDLE only), abort request (highest priority)
//   x, gen_en  : drive Gen_M
//   busy, idx  : running flag and current entry index
//   done       : one-clk pulse on normal completion
module gen_m_seq_ctrl #(
  parameter int N_ENTRY = gen_m_pkg::N_ENTRY,
  parameter int XW      = gen_m_pkg::XW,
  parameter int DW      = gen_m_pkg::DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce5ms,
  input  logic                     wr_en,
  input  logic [$clog2(N_ENTRY)-1:0] wr_addr,
  input  logic [XW-1:0]            wr_x,
  input  logic [DW-1:0]            wr_dwell,
  input  logic [$clog2(N_ENTRY):0] len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [XW-1:0]            x,
  output logic                     gen_en,
  output logic                     busy,
  output logic [$clog2(N_ENTRY)-1:0] idx,
  output logic                     done
);

  import gen_m_pkg::*;

  localparam int AW = $clog2(N_ENTRY);
  localparam int LW = AW + 1;
  localparam int WW = XW + DW;

  state_t        r_state;
  state_t        w_state_next;
  logic [XW-1:0] r_x;
  logic [XW-1:0] w_x_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_next;
  logic [LW-1:0] r_len;
  logic [LW-1:0] w_len_next;
  logic          r_loop;
  logic          w_loop_next;
  logic          r_done;
  logic          w_done_next;

  logic [AW-1:0] w_rd_addr;
  logic [WW-1:0] w_rd_data;
  logic [XW-1:0] w_rd_x;
  logic [DW-1:0] w_rd_dwell;
  logic          w_len_ok;
  logic          w_last;

  gen_m_prog_ram #(
    .N_ENTRY (N_ENTRY),
    .WW      (WW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_x, wr_dwell}),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  assign w_rd_x     = w_rd_data[WW-1:DW];
  assign w_rd_dwell = w_rd_data[DW-1:0];

  assign w_len_ok = (len != '0) && (len <= LW'(N_ENTRY));
  assign w_last   = ({1'b0, r_idx} == (r_len - LW'(1)));

  // The read port always points at the entry that would be loaded next:
  // entry 0 from IDLE or after the last entry, otherwise idx+1.
  assign w_rd_addr = ((r_state == ST_RUN) && !w_last) ? (r_idx + AW'(1)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_len   <= w_len_next;
      r_loop  <= w_loop_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    w_loop_next  = r_loop;
    w_done_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!stop && start && w_len_ok) begin
          w_len_next   = len;
          w_loop_next  = loop;
          w_x_next     = w_rd_x;
          w_cnt_next   = w_rd_dwell;
          w_idx_next   = '0;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (ce5ms) begin
          if (r_cnt != DW'(1)) begin
            // A zero dwell wraps here, giving 2^DW ticks in total.
            w_cnt_next = r_cnt - DW'(1);
          end else if (!w_last || r_loop) begin
            w_x_next   = w_rd_x;
            w_cnt_next = w_rd_dwell;
            w_idx_next = w_rd_addr;
          end else begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign x      = r_x;
  assign idx    = r_idx;
  assign done   = r_done;
  assign busy   = (r_state == ST_RUN);
  assign gen_en = (r_state == ST_RUN);

endmodule
